riscv_instr_mem_responder: RTL and testbench
============================================

// Module: riscv_instr_mem_responder
// PURPOSE
//   Slave end of the instruction-fetch req/gnt/rvalid protocol driven by the IF stage prefetch buffer.
//   Holds a word-organised instruction RAM, grants requests, returns read data after a fixed pipelined latency.
//   Used as the core-local instruction TCM and as the fetch-side memory model in core-level benches.
//   Programmable grant back-pressure (stall_i) exercises prefetch buffer stall paths.
// PARAMETERS
//   RDATA_WIDTH     32    read data width; 32 or 128 (matches prefetch buffer variant)
//   MEM_WORDS       1024  depth in RDATA_WIDTH words; power of two
//   READ_LAT        1     cycles from grant cycle to rvalid; legal 1..4
//   MAX_OUTSTANDING 2     max granted-but-not-returned requests; legal 1..4
// PORTS
//   clk             in   1            clock
//   rst_n           in   1            asynchronous reset, active-low
//   instr_req_i     in   1            fetch request
//   instr_addr_i    in   32           byte address; low log2(RDATA_WIDTH/8) bits ignored
//   instr_gnt_o     out  1            request accepted this cycle (combinational)
//   instr_rvalid_o  out  1            read data valid
//   instr_rdata_o   out  RDATA_WIDTH  read data
//   stall_i         in   1            suppress grant this cycle
//   we_i            in   1            preload/debug write enable
//   waddr_i         in   log2(MEM_WORDS) word index for write
//   wdata_i         in   RDATA_WIDTH  write data
//   busy_o          out  1            at least one request outstanding
// BEHAVIOUR
//   Reset: rst_n asynchronous, active-low; clock clk. While rst_n low: gnt=0, rvalid=0, rdata=0,
//     busy=0, outstanding count=0, latency pipeline cleared. RAM contents NOT reset.
//   Grant: gnt = rst_n & req & ~stall_i & (outstanding < MAX_OUTSTANDING). No gnt without req.
//     Address sampled only in the gnt cycle; req/addr may change freely while gnt=0.
//   Word index = addr[log2(RDATA_WIDTH/8) +: log2(MEM_WORDS)]; higher address bits ignored (wraps modulo MEM_WORDS).
//   RAM read at the clock edge ending the grant cycle; result travels a READ_LAT-deep valid/data shift pipe.
//   Latency: grant in cycle N -> rvalid=1 for exactly one cycle in cycle N+READ_LAT, with data.
//   Back-to-back grants every cycle give back-to-back rvalid; responses strictly in grant order.
//   rdata holds its last returned value while rvalid=0 (0 after reset).
//   Outstanding counter: +1 on gnt, -1 on rvalid, unchanged when both in same cycle; never exceeds
//     MAX_OUTSTANDING nor underflows. busy_o = (outstanding != 0). With MAX_OUTSTANDING < READ_LAT,
//     throughput is MAX_OUTSTANDING per READ_LAT cycles; grant re-enabled in the cycle rvalid frees a slot.
//   Write: we_i writes wdata_i to mem[waddr_i] at clock edge; independent of fetch traffic.
//     Write and granted read to same word in same cycle: read returns OLD data (read-first).
//   Reset mid-operation: in-flight responses discarded, no rvalid after reset release for pre-reset grants.
//   No flush/kill input: every grant is answered, even if the initiator branched away (initiator discards).
//   Simulation assertions: rvalid never asserted with outstanding==0; outstanding <= MAX_OUTSTANDING.
// TESTING
//   T1 preload mem[0..3]=0x11,0x22,0x33,0x44; req held, addr 0x0,0x4,0x8,0xC, READ_LAT=1 ->
//      gnt 4 consecutive cycles, rvalid cycles N+1..N+4 with 0x11..0x44 in order.
//   T2 READ_LAT=3, MAX_OUTSTANDING=2, req held -> gnt pattern 1,1,0,1,1,0..., never >2 outstanding, busy_o=1 throughout.
//   T3 stall_i=1 for 3 cycles with req=1 -> gnt=0, no rvalid; addr changes during stall, granted addr
//      after stall_i drops is the one returned.
//   T4 we_i to word 5 (0xDEAD) same cycle as granted read of addr 0x14 (old 0xBEEF) -> returns 0xBEEF;
//      next read of 0x14 returns 0xDEAD.
//   T5 addr 0x1000 with MEM_WORDS=1024, RDATA_WIDTH=32 -> returns mem[0]; addr 0x3 -> mem[0] (low bits ignored).
//   T6 rst_n pulsed low 1 cycle after gnt with READ_LAT=2 -> rvalid stays 0, rdata=0, busy_o=0; next
//      request after release behaves as T1.

Source files
------------

// File: rtl/riscv_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// riscv_instr_mem_responder
//
// Purpose:
//   Slave end of the instruction-fetch req/gnt/rvalid handshake. It holds a
//   word-organised instruction RAM, grants fetch requests and returns the read
//   data after a fixed, pipelined latency. It serves as the core-local
//   instruction TCM and as the fetch-side memory model in core-level benches.
//   stall_i lets a bench withhold grants to exercise prefetch-buffer stalls.
//
// Ports:
//   clk             in   1            clock
//   rst_n           in   1            asynchronous reset, active-low
//   instr_req_i     in   1            fetch request
//   instr_addr_i    in   32           byte address (sub-word bits ignored)
//   instr_gnt_o     out  1            request accepted this cycle (combinational)
//   instr_rvalid_o  out  1            read data valid
//   instr_rdata_o   out  RDATA_WIDTH  read data (holds last value when idle)
//   stall_i         in   1            suppress grant this cycle
//   we_i            in   1            preload/debug write enable
//   waddr_i         in   log2(MEM_WORDS) word index for write
//   wdata_i         in   RDATA_WIDTH  write data
//   busy_o          out  1            at least one request outstanding
// -----------------------------------------------------------------------------
module riscv_instr_mem_responder #(
    parameter int RDATA_WIDTH     = 32,
    parameter int MEM_WORDS       = 1024,
    parameter int READ_LAT        = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [RDATA_WIDTH-1:0]       instr_rdata_o,
    input  logic                         stall_i,
    input  logic                         we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr_i,
    input  logic [RDATA_WIDTH-1:0]       wdata_i,
    output logic                         busy_o
);

    localparam int OFF_W = $clog2(RDATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [RDATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [IDX_W-1:0]       rd_idx;
    logic [READ_LAT-1:0]    vld_q;
    logic [RDATA_WIDTH-1:0] data_q [READ_LAT];
    logic [RDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   gnt;
    logic                   rvalid;
    logic                   unused_addr_bits;

    // Sub-word offset bits and bits above the RAM depth do not select a word;
    // the upper ones make the address space wrap modulo MEM_WORDS.
    assign rd_idx           = instr_addr_i[OFF_W +: IDX_W];
    assign unused_addr_bits = ^{instr_addr_i[31:OFF_W+IDX_W], instr_addr_i[OFF_W-1:0]};

    assign rvalid = vld_q[READ_LAT-1];

    // A response leaving in this cycle frees its slot immediately, so a full
    // counter still allows a grant when rvalid is high. This keeps throughput
    // at MAX_OUTSTANDING per READ_LAT cycles when the window is the limit.
    assign gnt = rst_n & instr_req_i & ~stall_i & ((cnt_q < MAX_CNT) | rvalid);

    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case ({gnt, rvalid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (rvalid) begin
            rdata_d = data_q[READ_LAT-1];
        end
    end

    // Control state: valid pipe, outstanding count and the held read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            vld_q[0] <= gnt;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Data pipe: RAM is read at the edge closing the grant cycle. The write
    // below uses non-blocking assignment, so a same-cycle write to the same
    // word is not yet visible here and the read returns the old contents.
    always_ff @(posedge clk) begin
        if (gnt) begin
            data_q[0] <= mem_q[rd_idx];
        end
        for (int i = 1; i < READ_LAT; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rvalid;
    assign instr_rdata_o  = rdata_d;
    assign busy_o         = (cnt_q != '0);

`ifndef SYNTHESIS
    a_rvalid_has_owner : assert property (@(posedge clk) disable iff (!rst_n)
        rvalid |-> (cnt_q != '0));
    a_cnt_bounded : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= MAX_CNT);
`endif

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
module tb_riscv_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        stall;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [9:0]  waddr;

    logic [31:0] model_mem [1024];
    int          n_total = 0;
    int          n_pass  = 0;
    bit          done    = 1'b0;

    always #5 clk = ~clk;

    // Reference copy of everything the bench writes into the RAM.
    always @(posedge clk) begin
        if (we) model_mem[waddr] <= wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Three instances share the stimulus: READ_LAT 1, 3 and 2, window of 2.
    // Each owns a scoreboard queue filled on its grants and drained on its rvalids.
    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int RL = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        logic        gnt;
        logic        rvalid;
        logic        busy;
        logic [31:0] rdata;
        logic [31:0] exp_q[$];
        logic [31:0] last = '0;
        bit          final_done = 1'b0;

        riscv_instr_mem_responder #(
            .RDATA_WIDTH(32), .MEM_WORDS(1024), .READ_LAT(RL), .MAX_OUTSTANDING(2)
        ) dut (
            .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
            .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
            .stall_i(stall), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .busy_o(busy)
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                last = '0;
                check($sformatf("L%0d reset gnt", RL), {31'b0, gnt}, 32'd0);
                check($sformatf("L%0d reset rvalid", RL), {31'b0, rvalid}, 32'd0);
                check($sformatf("L%0d reset busy", RL), {31'b0, busy}, 32'd0);
                check($sformatf("L%0d reset rdata", RL), rdata, 32'd0);
            end else begin
                check($sformatf("L%0d busy", RL), {31'b0, busy}, {31'b0, exp_q.size() != 0});
                check($sformatf("L%0d outstanding<=2", RL), {31'b0, exp_q.size() <= 2}, 32'd1);
                if (rvalid) begin
                    if (exp_q.size() == 0) check($sformatf("L%0d rvalid without grant", RL), {31'b0, rvalid}, 32'd0);
                    else check($sformatf("L%0d rdata", RL), rdata, exp_q.pop_front());
                    last = rdata;
                end else begin
                    check($sformatf("L%0d rdata hold", RL), rdata, last);
                end
                if (gnt) exp_q.push_back(model_mem[addr[11:2]]);
            end
            if (done && !final_done) begin
                check($sformatf("L%0d all answered", RL), exp_q.size(), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; stall = 1'b0; we = 1'b0;
        addr = '0; waddr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Preload words 0..15
        for (int i = 0; i < 16; i++) begin
            we    = 1'b1;
            waddr = 10'(i);
            wdata = (i < 4) ? 32'(32'h11 * (i + 1)) : ((i == 5) ? 32'hBEEF : 32'(32'h1000 + i));
            tick();
        end
        we = 1'b0;
        tick();

        // T1: four back-to-back fetches, READ_LAT=1
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; addr = 32'(4 * i);
            @(negedge clk);
            check("T1 gnt", {31'b0, gi[0].gnt}, 32'd1);
            if (i > 0) begin
                check("T1 rvalid", {31'b0, gi[0].rvalid}, 32'd1);
                check("T1 rdata", gi[0].rdata, 32'(32'h11 * i));
            end
            tick();
        end
        req = 1'b0;
        @(negedge clk);
        check("T1 last rvalid", {31'b0, gi[0].rvalid}, 32'd1);
        check("T1 last rdata", gi[0].rdata, 32'h44);
        tick();
        idle(5);

        // T2: READ_LAT=3, window 2, request held
        for (int c = 0; c < 9; c++) begin
            req = 1'b1; addr = 32'(4 * (4 + c));
            @(negedge clk);
            check($sformatf("T2 gnt c%0d", c), {31'b0, gi[1].gnt}, {31'b0, (c % 3) != 2});
            if (c > 0) check("T2 busy", {31'b0, gi[1].busy}, 32'd1);
            tick();
        end
        idle(8);

        // T3: stall withholds grant while address moves
        stall = 1'b1; req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr = 32'(32'h20 + 4 * k);
            @(negedge clk);
            check("T3 gnt L1", {31'b0, gi[0].gnt}, 32'd0);
            check("T3 gnt L3", {31'b0, gi[1].gnt}, 32'd0);
            check("T3 gnt L2", {31'b0, gi[2].gnt}, 32'd0);
            check("T3 rvalid", {31'b0, gi[0].rvalid}, 32'd0);
            tick();
        end
        stall = 1'b0; addr = 32'h2C;
        @(negedge clk);
        check("T3 gnt after stall", {31'b0, gi[0].gnt}, 32'd1);
        tick();
        req = 1'b0;
        @(negedge clk);
        check("T3 rvalid", {31'b0, gi[0].rvalid}, 32'd1);
        check("T3 rdata", gi[0].rdata, 32'h100B);
        tick();
        idle(5);

        // T4: same-cycle write and read of word 5 is read-first
        req = 1'b1; addr = 32'h14; we = 1'b1; waddr = 10'd5; wdata = 32'hDEAD;
        @(negedge clk);
        check("T4 gnt", {31'b0, gi[0].gnt}, 32'd1);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("T4 old rvalid", {31'b0, gi[0].rvalid}, 32'd1);
        check("T4 old rdata", gi[0].rdata, 32'hBEEF);
        tick();
        req = 1'b0;
        @(negedge clk);
        check("T4 new rdata", gi[0].rdata, 32'hDEAD);
        tick();
        idle(5);

        // T5: address wrap and ignored byte bits
        req = 1'b1; addr = 32'h1000;
        @(negedge clk);
        check("T5 gnt", {31'b0, gi[0].gnt}, 32'd1);
        tick();
        addr = 32'h3;
        @(negedge clk);
        check("T5 wrap rdata", gi[0].rdata, 32'h11);
        tick();
        req = 1'b0;
        @(negedge clk);
        check("T5 low bits rvalid", {31'b0, gi[0].rvalid}, 32'd1);
        check("T5 low bits rdata", gi[0].rdata, 32'h11);
        tick();
        idle(5);

        // T6: reset one cycle after a grant on the READ_LAT=2 instance
        req = 1'b1; addr = 32'h4;
        @(negedge clk);
        check("T6 gnt", {31'b0, gi[2].gnt}, 32'd1);
        tick();
        req = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("T6 rvalid", {31'b0, gi[2].rvalid}, 32'd0);
            check("T6 rdata", gi[2].rdata, 32'd0);
            check("T6 busy", {31'b0, gi[2].busy}, 32'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            req = 1'b1; addr = 32'(4 * i);
            @(negedge clk);
            check("T6 regrant", {31'b0, gi[2].gnt}, 32'd1);
            tick();
        end
        req = 1'b0;
        @(negedge clk);
        check("T6 rvalid after release", {31'b0, gi[2].rvalid}, 32'd1);
        check("T6 rdata first", gi[2].rdata, 32'h11);
        tick();
        @(negedge clk);
        check("T6 rdata second", gi[2].rdata, 32'h22);
        tick();
        idle(5);

        done = 1'b1;
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
